// File: rtl/ff_pipe_reset_de_pkg.sv
// Shared constants for the reset/data-enable pipeline: reset level and default geometry.
package ff_pipe_reset_de_pkg;

  localparam logic RESET_ACTIVE = 1'b0;
  localparam int   DEF_WIDTH    = 8;
  localparam int   DEF_DEPTH    = 3;
  localparam int   DEF_CNT_W    = 2;

endpackage

// File: rtl/ff_pipe_reset_de_if.sv
// Producer/consumer bundle for the pipeline; the producer owns D/De/Stall/Sclr.
import ff_pipe_reset_de_pkg::*;

interface ff_pipe_reset_de_if #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
);
  // De qualifies D on any edge where Stall=0 and Sclr=0; Q_valid qualifies Q every cycle.
  // There is no backpressure: a De=1 presented during Stall is lost and flagged on Drop.
  logic [WIDTH-1:0] D;
  logic             De;
  logic             Stall;
  logic             Sclr;
  logic [WIDTH-1:0] Q;
  logic             Q_valid;
  logic [CNT_W-1:0] Occ;
  logic             Drop;

  modport master (output D, De, Stall, Sclr, input Q, Q_valid, Occ, Drop);
  modport slave  (input D, De, Stall, Sclr, output Q, Q_valid, Occ, Drop);
endinterface

// File: rtl/ff_pipe_reset_de_stage.sv
// One pipeline slot: WIDTH-bit data register plus its valid flop, async reset.
import ff_pipe_reset_de_pkg::*;

module ff_de_stage #(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             ld_en,
  input  logic             hold,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  input  logic             v_in,
  output logic [WIDTH-1:0] q,
  output logic             v_out
);

  // Data only moves under ld_en so bubbles never disturb the register contents.
  always_ff @(posedge clk or negedge rst_b) begin
    if (rst_b == RESET_ACTIVE) begin
      q     <= RESET_VAL;
      v_out <= 1'b0;
    end else if (clr) begin
      q     <= RESET_VAL;
      v_out <= 1'b0;
    end else if (!hold) begin
      v_out <= v_in;
      if (ld_en) q <= d;
    end
  end

endmodule

// File: rtl/ff_pipe_reset_de.sv
// Fixed-latency W-bit, N-stage delay line with valid tracking, stall, flush and drop flag.
import ff_pipe_reset_de_pkg::*;

module ff_pipe_reset_de #(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter int               DEPTH     = DEF_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CNT_W     = DEF_CNT_W
) (
  input logic               Clk,
  input logic               Reset_b,
  ff_pipe_reset_de_if.slave bus
);

  logic [WIDTH-1:0] data [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [CNT_W-1:0] occ;
  logic             drop;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic [WIDTH-1:0] d_in;
    logic             v_in;

    if (k == 0) begin : g_head
      assign d_in = bus.D;
      assign v_in = bus.De;
    end else begin : g_body
      assign d_in = data[k-1];
      assign v_in = valid[k-1];
    end

    ff_de_stage #(
      .WIDTH    (WIDTH),
      .RESET_VAL(RESET_VAL)
    ) u_stage (
      .clk  (Clk),
      .rst_b(Reset_b),
      .ld_en(v_in),
      .hold (bus.Stall),
      .clr  (bus.Sclr),
      .d    (d_in),
      .v_in (v_in),
      .q    (data[k]),
      .v_out(valid[k])
    );
  end

  // Occ tracks entries minus exits so it never needs a popcount over the valid bits.
  always_ff @(posedge Clk or negedge Reset_b) begin
    if (Reset_b == RESET_ACTIVE) begin
      occ  <= '0;
      drop <= 1'b0;
    end else if (bus.Sclr) begin
      occ  <= '0;
      drop <= 1'b0;
    end else if (bus.Stall) begin
      drop <= bus.De;
    end else begin
      occ  <= occ + CNT_W'(bus.De) - CNT_W'(valid[DEPTH-1]);
      drop <= 1'b0;
    end
  end

  assign bus.Q       = data[DEPTH-1];
  assign bus.Q_valid = valid[DEPTH-1];
  assign bus.Occ     = occ;
  assign bus.Drop    = drop;

endmodule
